// File: rtl/vga_image_scanner.sv
// vga_image_scanner: 640x480@60 VGA raster scanner that fetches a packed RGB565 image from an upstream RAM.
//   clk, rst          50 MHz system clock, asynchronous active-high reset
//   ram_addr/ram_data 18-bit word address out, 32-bit word back one clk later (two RGB565 pixels)
//   vga_clk           25 MHz pixel clock (falls on every pixel tick)
//   hsync, vsync      active-low syncs
//   blank_n           high during active video
//   r, g, b           8-bit colour
//   frame_start       one-clk pulse when outputs present pixel (0,0)
module vga_image_scanner #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int IMG_W = 300,
  parameter int IMG_H = 300,
  parameter int IMG_X = 170,
  parameter int IMG_Y = 90,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [17:0] ram_addr,
  input  logic [31:0] ram_data,
  output logic        vga_clk,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        frame_start
);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HA = 10'(H_ACTIVE);
  localparam logic [9:0] VA = 10'(V_ACTIVE);
  localparam logic [9:0] HS_B = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_E = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_B = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_E = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] IX = 10'(IMG_X);
  localparam logic [9:0] IX_E = 10'(IMG_X + IMG_W);
  localparam logic [9:0] IY = 10'(IMG_Y);
  localparam logic [9:0] IY_E = 10'(IMG_Y + IMG_H);
  localparam logic [17:0] LAST_WORD = 18'(IMG_W * IMG_H / 2 - 1);
  logic ph, run, in_img, half, active;
  logic [9:0] h, v, h_nx, v_nx;
  logic [15:0] px;
  logic [23:0] rgb;
  assign vga_clk = ph;
  always_comb begin
    h_nx = (h == H_LAST) ? 10'd0 : h + 10'd1;
    v_nx = (h != H_LAST) ? v : (v == V_LAST) ? 10'd0 : v + 10'd1;
    in_img = h >= IX && h < IX_E && v >= IY && v < IY_E;
    active = h < HA && v < VA;
    // image width and origin parity make the pixel-index LSB a function of h alone
    half = h[0] ^ IX[0];
    px = half ? ram_data[31:16] : ram_data[15:0];
    rgb = {px[15:11], px[15:13], px[10:5], px[10:9], px[4:0], px[4:2]};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph <= 1'b0;
      run <= 1'b0;
      h <= '0;
      v <= '0;
      ram_addr <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      blank_n <= 1'b0;
      {r, g, b} <= '0;
      frame_start <= 1'b0;
    end else begin
      ph <= ~ph;
      frame_start <= ph && run && h == 10'd0 && v == 10'd0;
      if (ph) begin
        // first tick after reset only arms the pipeline so that (0,0) is fetched like any other pixel
        run <= 1'b1;
        if (run) begin
          h <= h_nx;
          v <= v_nx;
          ram_addr <= (h_nx == 10'd0 && v_nx == 10'd0) ? 18'd0 :
                      (in_img && half && ram_addr != LAST_WORD) ? ram_addr + 18'd1 : ram_addr;
          hsync <= !(h >= HS_B && h < HS_E);
          vsync <= !(v >= VS_B && v < VS_E);
          blank_n <= active;
          {r, g, b} <= !active ? 24'd0 : in_img ? rgb : BG_COLOR;
        end
      end
    end
  end
endmodule

// File: tb/tb_vga_image_scanner.sv
// tb_vga_image_scanner: scoreboard bench for vga_image_scanner on a reduced raster.
module tb_vga_image_scanner;
  localparam int HT = 56;
  localparam int FRAME_CLK = 4032;
  localparam logic [23:0] BG = 24'h203040;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [17:0] ram_addr;
  logic [31:0] ram_data;
  logic vga_clk, hsync, vsync, blank_n, frame_start;
  logic [7:0] r, g, b;
  int checks = 0;
  int failures = 0;
  int fnum = -1;
  int idx = 0;
  bit started = 1'b0;
  typedef struct {int f; int idx; bit kind; logic [31:0] exp; string nm;} ent_t;
  ent_t sb[$];
  vga_image_scanner #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .IMG_W(20), .IMG_H(10), .IMG_X(10), .IMG_Y(6),
    .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst(rst), .ram_addr(ram_addr), .ram_data(ram_data),
    .vga_clk(vga_clk), .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
    .r(r), .g(g), .b(b), .frame_start(frame_start)
  );
  always #10 clk = ~clk;
  function automatic logic [31:0] mem(input logic [17:0] a);
    logic [15:0] w;
    w = a[15:0];
    return (a == 18'd0) ? 32'h1234F800 : {~w, w ^ 16'h5A3C};
  endfunction
  always @(posedge clk) ram_data <= mem(ram_addr);
  function automatic logic [31:0] px(input logic bl, input logic hs, input logic vs, input logic [23:0] c);
    return {5'b0, bl, hs, vs, c};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask
  task automatic add(input int f, input int x, input int y, input bit kind, input logic [31:0] e, input string nm);
    sb.push_back('{f, y * HT + x - (kind ? 1 : 0), kind, e, nm});
  endtask
  task automatic push_frame(input int f);
    add(f, 0, 0, 0, px(1, 1, 1, BG), "px_origin");
    add(f, 9, 6, 0, px(1, 1, 1, BG), "px_left_of_img");
    add(f, 10, 6, 0, px(1, 1, 1, 24'hFF0000), "px_img_first");
    add(f, 11, 6, 0, px(1, 1, 1, 24'h1045A5), "px_img_hi_half");
    add(f, 12, 6, 0, px(1, 1, 1, 24'h5A45EF), "px_word1_lo");
    add(f, 13, 6, 0, px(1, 1, 1, 24'hFFFFF7), "px_word1_hi");
    add(f, 30, 6, 0, px(1, 1, 1, BG), "px_right_of_img");
    add(f, 29, 15, 0, px(1, 1, 1, 24'hFFF3E7), "px_img_last");
    add(f, 10, 16, 0, px(1, 1, 1, BG), "px_below_img");
    add(f, 39, 29, 0, px(1, 1, 1, BG), "px_last_active");
    add(f, 40, 29, 0, px(0, 1, 1, 0), "px_h_blank");
    add(f, 0, 30, 0, px(0, 1, 1, 0), "px_v_blank");
    add(f, 43, 3, 0, px(0, 1, 1, 0), "hs_before");
    add(f, 44, 3, 0, px(0, 0, 1, 0), "hs_first");
    add(f, 51, 3, 0, px(0, 0, 1, 0), "hs_last");
    add(f, 52, 3, 0, px(0, 1, 1, 0), "hs_after");
    add(f, 0, 31, 0, px(0, 1, 1, 0), "vs_before");
    add(f, 0, 32, 0, px(0, 1, 0, 0), "vs_first");
    add(f, 55, 33, 0, px(0, 1, 0, 0), "vs_last");
    add(f, 0, 34, 0, px(0, 1, 1, 0), "vs_after");
    add(f, 45, 10, 0, px(0, 0, 1, 0), "px_blank_in_hs");
    add(f, 9, 6, 1, 0, "addr_pre_img");
    add(f, 10, 6, 1, 0, "addr_img_start");
    add(f, 12, 6, 1, 1, "addr_word1");
    add(f, 30, 6, 1, 10, "addr_after_row0");
    add(f, 10, 7, 1, 10, "addr_row1");
    add(f, 28, 15, 1, 99, "addr_last_word");
    add(f, 30, 15, 1, 99, "addr_hold_last");
    add(f, 55, 35, 1, 99, "addr_hold_eof");
    add(f, 56, 35, 1, 0, "addr_wrap");
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_out"}, px(blank_n, hsync, vsync, {r, g, b}), px(0, 1, 1, 0));
    chk({tag, "_addr"}, 32'(ram_addr), 0);
    chk({tag, "_fs_clk"}, {30'd0, frame_start, vga_clk}, 0);
  endtask
  task automatic chk_latency(input string nm);
    int k;
    k = 0;
    while (k < 12 && !frame_start) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(nm, k, 4);
  endtask
  // monitor: tracks pixel index from frame_start and pops matching scoreboard entries
  int cyc = 0;
  int last_fs = 0;
  bit last_ok = 1'b0;
  bit prev_fs = 1'b0;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      started = 1'b0;
      last_ok = 1'b0;
    end else if (frame_start) begin
      if (prev_fs) chk("fs_width", 32'(prev_fs), 0);
      if (last_ok) chk("frame_period", cyc - last_fs, FRAME_CLK);
      last_fs = cyc;
      last_ok = 1'b1;
      fnum++;
      idx = 0;
      started = 1'b1;
    end else if (started && !vga_clk) idx++;
    prev_fs = frame_start;
    if (started && !rst && !vga_clk)
      for (int i = sb.size() - 1; i >= 0; i--)
        if (sb[i].f == fnum && sb[i].idx == idx) begin
          chk(sb[i].nm, sb[i].kind ? 32'(ram_addr) : px(blank_n, hsync, vsync, {r, g, b}), sb[i].exp);
          sb.delete(i);
        end
  end
  initial begin
    int n;
    push_frame(0);
    push_frame(2);
    repeat (3) @(negedge clk);
    chk_reset("rst_hold");
    rst = 1'b0;
    chk_latency("first_fs_latency");
    n = 0;
    while (n < 3 * FRAME_CLK && !(fnum == 1 && idx == 10 * HT + 15)) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("reach_mid_frame", 32'(fnum == 1 && idx == 10 * HT + 15), 1);
    rst = 1'b1;
    #1;
    chk_reset("rst_async");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_latency("restart_fs_latency");
    n = 0;
    while (n < 3 * FRAME_CLK && fnum < 3) begin
      @(posedge clk);
      n++;
    end
    chk("reach_frame3", 32'(fnum), 3);
    repeat (10) @(posedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
